fc_stream_layer: RTL and testbench
==================================

// Module: fc_stream_layer
// PURPOSE
//  Consumer end of the serial flattened-feature stream. Accepts one signed Q8.8 sample
//  per handshake and runs N_OUT parallel multiply-accumulates against a weight matrix.
//  After N_IN samples it adds the bias, rescales, saturates and optionally applies ReLU.
//  It then presents N_OUT results as one registered vector. Sits between the flattener and the classifier/argmax.
// PARAMETERS
//  N_IN       4   samples per frame (flattened feature length)
//  N_OUT      2   output neurons
//  DATA_W     16  sample/weight/bias/result width, signed
//  FRAC_BITS  8   fractional bits of the fixed-point format
//  ACC_W      40  accumulator width, signed; must be >= 2*DATA_W+clog2(N_IN)+1
//  RELU       1   1: clamp negative results to 0; 0: pass signed
// PORTS
//  clk        in   1                   rising-edge clock
//  reset      in   1                   asynchronous, active-high reset
//  clear      in   1                   sync abort: drop partial frame, return to ACCUM
//  in_data    in   DATA_W              signed input sample
//  in_valid   in   1                   in_data valid this cycle
//  in_ready   out  1                   layer can accept a sample this cycle
//  weights    in   DATA_W [0:N_OUT*N_IN-1]  W[o][i] at index o*N_IN+i, static during a frame
//  bias       in   DATA_W [0:N_OUT-1]  per-neuron bias, same Q format
//  fc_out     out  DATA_W [0:N_OUT-1]  result vector, held until next result
//  out_valid  out  1                   one-cycle pulse, fc_out updated this cycle
//  busy       out  1                   high while a frame is partially received or finishing
// BEHAVIOUR
//  - Reset: state=ACCUM, sample count=0, accumulators=0, fc_out=0, out_valid=0, in_ready=1, busy=0.
//  - Transfer occurs on a rising edge with in_valid && in_ready. Gaps in in_valid are allowed, with no timeout.
//  - States:
//    - ACCUM: in_ready=1. Each transfer with count i does acc[o] += in_data*W[o][i] for all o.
//      The product is full 2*DATA_W signed, sign-extended to ACC_W. Count increments.
//      A transfer with count==N_IN-1 moves to SCALE and resets the count to 0.
//    - SCALE (1 cycle): in_ready=0. res = (acc + (bias<<<FRAC_BITS)) >>> FRAC_BITS, an arithmetic shift that floors.
//      Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. If RELU, negative results become 0.
//      Register into fc_out and go to OUT.
//    - OUT (1 cycle): out_valid=1, in_ready=0. Clear accumulators. Go to ACCUM.
//  - Latency: last sample accepted at edge E. fc_out/out_valid are visible after E+1.
//    out_valid drops and in_ready rises after E+2. Minimum frame period is N_IN+2 cycles.
//  - busy = (count!=0) || state!=ACCUM.
//  - clear has priority over a same-cycle transfer. A sample presented with clear is not accepted.
//    clear zeroes the count and accumulators and forces ACCUM. fc_out is retained and no out_valid is produced.
//    clear during SCALE/OUT aborts the result, so neither fc_out nor out_valid changes.
//  - Reset mid-frame returns all outputs to reset values immediately (async assert). The partial frame is lost.
//  - The count never exceeds N_IN-1 and wraps only through SCALE.
//  - weights/bias changing mid-frame give undefined results. This is not checked.
// STRUCTURE
//  - Shared package cnn_pkg:
//    - DATA_W, FRAC_BITS
//    - typedef sample_t (signed DATA_W)
//    - function sat_q(acc) for narrowing with saturation
//    - fc_state_e {ACCUM, SCALE, OUT}
//  - One sub-module fc_mac_lane (per neuron). It holds the accumulator and has ports clk, reset, clr, en, x, w, bias, res.
//    The top generates N_OUT lanes and owns the FSM, count and weight indexing.
// TESTING
//  Default params unless noted. 1.0=256.
//  1. Basic: in=256 x4 back-to-back, W[0][*]=128, W[1][*]=-64, bias=0.
//     Expect fc_out=(512,0), with (512,-256) when RELU=0. out_valid one cycle, 1 cycle after the 4th transfer.
//  2. Bias + gaps: in=(256,0,-256,512) with 1-3 idle cycles between, W[0][*]=256, bias[0]=128.
//     Expect fc_out[0]=640. in_ready=0 exactly 2 cycles after the last transfer.
//  3. Saturation: in=32767 x4, W[o][*]=32767. Expect fc_out=32767.
//     With W=-32767 and RELU=0, expect -32768.
//  4. Back-to-back frames: hold in_valid=1 continuously. Expect transfers stall 2 cycles per frame.
//     Second frame's result is independent of the first (accumulator cleared).
//  5. clear/reset mid-frame: send 2 samples, pulse clear (with in_valid=1), then send a full frame.
//     Expect no out_valid for the partial frame and a correct result for the new frame.
//     Repeat with async reset after 3 samples. Expect fc_out=0, busy=0 immediately.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared fixed-point types, FSM encoding and the saturating narrow
// used by the streaming CNN layers.
package cnn_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ACCUM,
    SCALE,
    OUT
  } fc_state_e;

  localparam longint S_MAX = (64'sd1 <<< (DATA_W-1)) - 64'sd1;
  localparam longint S_MIN = -(64'sd1 <<< (DATA_W-1));

  function automatic sample_t sat_q(input logic signed [63:0] acc);
    if (acc > S_MAX) return sample_t'(S_MAX);
    if (acc < S_MIN) return sample_t'(S_MIN);
    return acc[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output neuron: accumulates x*w over a frame and exposes the
// bias-added, rescaled, saturated (optionally rectified) result.
module fc_mac_lane
  import cnn_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int RELU  = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    clr,
  input  logic    en,
  input  sample_t x,
  input  sample_t w,
  input  sample_t bias,
  output sample_t res
);

  localparam int PW = 2 * DATA_W;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shift;
  logic signed [63:0]      w_wide;
  sample_t                 w_sat;

  assign w_prod     = PW'(x) * PW'(w);
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};

  // Arithmetic right shift floors toward -inf
  assign w_sum   = r_acc + (w_bias_ext <<< FRAC_BITS);
  assign w_shift = w_sum >>> FRAC_BITS;
  assign w_wide  = {{(64-ACC_W){w_shift[ACC_W-1]}}, w_shift};
  assign w_sat   = sat_q(w_wide);
  assign res     = (RELU != 0 && w_sat[DATA_W-1]) ? '0 : w_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

endmodule

// File: rtl/fc_stream_layer.sv
// Streaming fully-connected layer: one sample per handshake, N_OUT
// parallel MAC lanes, registered result vector with a valid pulse.
module fc_stream_layer
  import cnn_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int ACC_W = 40,
  parameter int RELU  = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    clear,
  input  sample_t in_data,
  input  logic    in_valid,
  output logic    in_ready,
  input  sample_t weights [0:N_OUT*N_IN-1],
  input  sample_t bias    [0:N_OUT-1],
  output sample_t fc_out  [0:N_OUT-1],
  output logic    out_valid,
  output logic    busy
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

  fc_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ov;
  sample_t          r_fc  [0:N_OUT-1];
  sample_t          w_res [0:N_OUT-1];
  logic             w_xfer;
  logic             w_clr;

  assign in_ready  = (r_state == ACCUM);
  assign w_xfer    = in_valid && in_ready && !clear;
  assign w_clr     = clear || (r_state == OUT);
  assign busy      = (r_cnt != '0) || (r_state != ACCUM);
  assign out_valid = r_ov;

  for (genvar o = 0; o < N_OUT; o++) begin : g_lane
    sample_t w_row [0:N_IN-1];

    for (genvar i = 0; i < N_IN; i++) begin : g_row
      assign w_row[i] = weights[o*N_IN+i];
    end

    fc_mac_lane #(
      .ACC_W(ACC_W),
      .RELU (RELU)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .clr  (w_clr),
      .en   (w_xfer),
      .x    (in_data),
      .w    (w_row[r_cnt]),
      .bias (bias[o]),
      .res  (w_res[o])
    );

    assign fc_out[o] = r_fc[o];
  end

  // clear wins over everything, including a pending result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ACCUM;
      r_cnt   <= '0;
      r_ov    <= 1'b0;
      for (int o = 0; o < N_OUT; o++) r_fc[o] <= '0;
    end else begin
      r_ov <= 1'b0;
      if (clear) begin
        r_state <= ACCUM;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          ACCUM: begin
            if (w_xfer) begin
              if (r_cnt == LAST) begin
                r_cnt   <= '0;
                r_state <= SCALE;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          SCALE: begin
            for (int o = 0; o < N_OUT; o++) r_fc[o] <= w_res[o];
            r_ov    <= 1'b1;
            r_state <= OUT;
          end
          OUT: r_state <= ACCUM;
          default: r_state <= ACCUM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fc_stream_layer.sv
// Bench for fc_stream_layer: directed cases plus random frames,
// results compared against an arithmetic reference model.
module tb_fc_stream_layer;
  import cnn_pkg::*;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  logic    clear = 1'b0;
  logic    in_valid = 1'b0;
  sample_t in_data = '0;
  sample_t wts  [0:N_OUT*N_IN-1];
  sample_t bias [0:N_OUT-1];
  sample_t fc_r [0:N_OUT-1];
  sample_t fc_n [0:N_OUT-1];
  logic    rdy_r, rdy_n, ov_r, ov_n, busy_r, busy_n;

  sample_t frame [0:N_IN-1];
  longint  q_r[$];
  longint  q_n[$];
  int      errs = 0;
  int      checks = 0;

  fc_stream_layer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(40), .RELU(1)
  ) u_dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_r),
    .weights(wts), .bias(bias), .fc_out(fc_r),
    .out_valid(ov_r), .busy(busy_r)
  );

  fc_stream_layer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(40), .RELU(0)
  ) u_dut_n (
    .clk(clk), .reset(reset), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_n),
    .weights(wts), .bias(bias), .fc_out(fc_n),
    .out_valid(ov_n), .busy(busy_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(input int o, input bit relu);
    longint acc = 0;
    for (int i = 0; i < N_IN; i++)
      acc += longint'(frame[i]) * longint'(wts[o*N_IN+i]);
    acc = (acc + longint'(bias[o]) * (64'sd1 <<< FRAC_BITS)) >>> FRAC_BITS;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return acc;
  endfunction

  function automatic sample_t rnd(input int span);
    int v;
    v = int'($urandom_range(0, 2 * span)) - span;
    return sample_t'(v);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (ov_r) begin
        if (q_r.size() < N_OUT) chk("spurious out_valid relu", q_r.size(), N_OUT);
        else for (int o = 0; o < N_OUT; o++)
          chk($sformatf("relu fc_out[%0d]", o), fc_r[o], q_r.pop_front());
      end
      if (ov_n) begin
        if (q_n.size() < N_OUT) chk("spurious out_valid lin", q_n.size(), N_OUT);
        else for (int o = 0; o < N_OUT; o++)
          chk($sformatf("lin fc_out[%0d]", o), fc_n[o], q_n.pop_front());
      end
    end
  end

  task automatic xfer(input sample_t d, output int waits);
    bit acc;
    waits = 0;
    in_data = d;
    in_valid = 1'b1;
    do begin
      acc = rdy_r;
      @(posedge clk);
      @(negedge clk);
      waits++;
    end while (!acc && waits < 20);
    if (!acc) chk("xfer timeout", waits, 1);
  endtask

  task automatic send_frame(input int gmin, input int gmax,
                            input bit timing, output int first_w);
    int w, k;
    first_w = 0;
    for (int i = 0; i < N_IN; i++) begin
      if (i > 0 && gmax > 0) begin
        k = int'($urandom_range(gmin, gmax));
        if (k > 0) in_valid = 1'b0;
        repeat (k) @(negedge clk);
      end
      xfer(frame[i], w);
      if (i == 0) first_w = w;
    end
    for (int o = 0; o < N_OUT; o++) begin
      q_r.push_back(model(o, 1'b1));
      q_n.push_back(model(o, 1'b0));
    end
    if (timing) begin
      in_valid = 1'b0;
      chk("scale out_valid", ov_r, 0);
      chk("scale in_ready", rdy_r, 0);
      chk("scale busy", busy_r, 1);
      @(negedge clk);
      chk("out out_valid", ov_r, 1);
      chk("out in_ready", rdy_r, 0);
      @(negedge clk);
      chk("idle out_valid", ov_r, 0);
      chk("idle in_ready", rdy_r, 1);
      chk("idle busy", busy_r, 0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    in_valid = 1'b0;
    while (busy_r && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("idle wait", busy_r, 0);
  endtask

  task automatic rand_setup(input int span);
    for (int i = 0; i < N_OUT*N_IN; i++) wts[i] = rnd(span);
    for (int o = 0; o < N_OUT; o++) bias[o] = rnd(span);
    for (int i = 0; i < N_IN; i++) frame[i] = rnd(span);
  endtask

  initial begin
    int fw, w;
    for (int i = 0; i < N_OUT*N_IN; i++) wts[i] = '0;
    for (int o = 0; o < N_OUT; o++) bias[o] = '0;
    repeat (2) @(negedge clk);
    chk("rst fc_out[0]", fc_r[0], 0);
    chk("rst fc_out[1]", fc_r[1], 0);
    chk("rst out_valid", ov_r, 0);
    chk("rst in_ready", rdy_r, 1);
    chk("rst busy", busy_r, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < N_IN; i++) begin
      frame[i] = 16'sd256;
      wts[i] = 16'sd128;
      wts[N_IN+i] = -16'sd64;
    end
    send_frame(0, 0, 1'b1, fw);
    chk("basic relu o0", fc_r[0], 512);
    chk("basic relu o1", fc_r[1], 0);
    chk("basic lin o1", fc_n[1], -256);

    frame[0] = 16'sd256; frame[1] = 16'sd0;
    frame[2] = -16'sd256; frame[3] = 16'sd512;
    for (int i = 0; i < N_IN; i++) wts[i] = 16'sd256;
    bias[0] = 16'sd128;
    send_frame(1, 3, 1'b1, fw);
    chk("bias gaps o0", fc_r[0], 640);

    bias[0] = '0;
    for (int i = 0; i < N_IN; i++) begin
      frame[i] = 16'sd32767;
      wts[i] = 16'sd32767;
      wts[N_IN+i] = -16'sd32767;
    end
    send_frame(0, 0, 1'b1, fw);
    chk("sat pos", fc_r[0], 32767);
    chk("sat relu neg", fc_r[1], 0);
    chk("sat lin neg", fc_n[1], -32768);

    rand_setup(512);
    send_frame(0, 0, 1'b0, fw);
    for (int i = 0; i < N_IN; i++) frame[i] = rnd(512);
    send_frame(0, 0, 1'b0, fw);
    chk("b2b stall", fw, 3);
    wait_idle();

    rand_setup(512);
    xfer(frame[0], w);
    xfer(frame[1], w);
    clear = 1'b1;
    in_data = rnd(512);
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clear busy", busy_r, 0);
    chk("clear in_ready", rdy_r, 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < N_IN; i++) frame[i] = rnd(512);
    send_frame(0, 2, 1'b1, fw);

    bias[1] = -16'sd1000;
    wts[N_IN] = 16'sd300;
    frame[0] = 16'sd256;
    for (int i = 1; i < N_IN; i++) frame[i] = '0;
    send_frame(0, 0, 1'b1, fw);
    for (int i = 0; i < 3; i++) xfer(rnd(512), w);
    #2 reset = 1'b1;
    #1;
    chk("arst fc_out[1]", fc_n[1], 0);
    chk("arst busy", busy_r, 0);
    chk("arst in_ready", rdy_r, 1);
    chk("arst out_valid", ov_r, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rand_setup(512);
    send_frame(0, 0, 1'b1, fw);

    for (int f = 0; f < 24; f++) begin
      wait_idle();
      rand_setup((f % 4 == 3) ? 32767 : 512);
      send_frame(0, 2, 1'(f % 2), fw);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("pending relu", q_r.size(), 0);
    chk("pending lin", q_n.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
